// File: rtl/adv_timer_cntrl_pkg.sv
// Shared definitions for the multi-channel advanced-timer control sequencer:
// status bit positions, the per-channel status flag word and small decode helpers.
package adv_timer_cntrl_pkg;

   // Bit positions of the flags inside each channel's status word
   localparam int STAT_PENDING = 0;
   localparam int STAT_ACTIVE  = 1;
   localparam int STAT_DONE    = 2;

   // Number of meaningful flag bits; the rest of the status word reads as zero
   localparam int STAT_FLAGS_W = 3;

   // Per-channel status flags; member order matches the bit positions above
   typedef struct packed {
      logic done;
      logic active;
      logic pending;
   } chan_stat_t;

   // A launch is a start event seen by a channel that is not yet running
   function automatic logic chan_launch(input logic start_e, input logic active);
      return start_e & ~active;
   endfunction

   // One-shot auto-stop: only when no explicit start/stop overrides it this cycle
   function automatic logic chan_autostop(input logic start_e, input logic stop_e,
                                          input logic active, input logic oneshot,
                                          input logic cnt_update);
      return ~start_e & ~stop_e & active & oneshot & cnt_update;
   endfunction

endpackage

// File: rtl/timer_cntrl_chan.sv
// One timer channel of the control sequencer: holds the running, pending-update
// and done flags and decodes the counter reset / update strobes for its slice.
module timer_cntrl_chan
   import adv_timer_cntrl_pkg::*;
#(
   parameter bit DEFER_UPD = 1'b1
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       start_e_i,
   input  logic       stop_e_i,
   input  logic       cfg_rst_i,
   input  logic       cfg_update_i,
   input  logic       cfg_oneshot_i,
   input  logic       status_clr_i,
   input  logic       cnt_update_i,
   output logic       ctrl_cnt_upd_o,
   output logic       ctrl_all_upd_o,
   output logic       ctrl_rst_o,
   output logic       ctrl_active_o,
   output chan_stat_t stat_o
);

   logic r_active;
   logic r_pending;
   logic r_done;

   logic w_launch;
   logic w_autostop;
   logic w_upd_allowed;

   assign w_launch      = chan_launch(start_e_i, r_active);
   assign w_autostop    = chan_autostop(start_e_i, stop_e_i, r_active, cfg_oneshot_i, cnt_update_i);
   // With deferral, a counter update only reloads the shadows when a config update is waiting
   assign w_upd_allowed = r_pending | ~DEFER_UPD;

   // Decode the same-cycle strobes; a launch forces a full counter reset and reload
   always_comb begin
      ctrl_rst_o     = cfg_rst_i;
      ctrl_cnt_upd_o = cfg_update_i;
      ctrl_all_upd_o = cnt_update_i & w_upd_allowed;
      if (w_launch) begin
         ctrl_rst_o     = 1'b1;
         ctrl_cnt_upd_o = 1'b1;
         ctrl_all_upd_o = 1'b1;
      end
   end

   // Running flag: start beats stop, stop beats the one-shot auto-stop
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_active <= 1'b0;
      end else if (start_e_i) begin
         r_active <= 1'b1;
      end else if (stop_e_i) begin
         r_active <= 1'b0;
      end else if (w_autostop) begin
         r_active <= 1'b0;
      end
   end

   // Pending shadow update: a new request beats a same-cycle consuming event
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_pending <= 1'b0;
      end else if (cfg_update_i) begin
         r_pending <= 1'b1;
      end else if (w_launch || cnt_update_i) begin
         r_pending <= 1'b0;
      end
   end

   // Sticky done flag: set by auto-stop, cleared by software or by the next launch
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_done <= 1'b0;
      end else if (w_autostop) begin
         r_done <= 1'b1;
      end else if (w_launch || status_clr_i) begin
         r_done <= 1'b0;
      end
   end

   assign ctrl_active_o  = r_active;
   assign stat_o.done    = r_done;
   assign stat_o.active  = r_active;
   assign stat_o.pending = r_pending;

endmodule

// File: rtl/adv_timer_multi_cntrl.sv
// Multi-channel advanced-timer control sequencer. Merges per-channel and masked
// global start/stop strobes and drives N independent channel controllers, so all
// channels selected by the global mask launch in the same clock cycle.
module adv_timer_multi_cntrl
   import adv_timer_cntrl_pkg::*;
#(
   parameter int N_TIMERS  = 4,
   parameter int DEFER_UPD = 1,
   parameter int STATUS_W  = 8
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic [N_TIMERS-1:0]          cfg_start_i,
   input  logic [N_TIMERS-1:0]          cfg_stop_i,
   input  logic [N_TIMERS-1:0]          cfg_rst_i,
   input  logic [N_TIMERS-1:0]          cfg_update_i,
   input  logic [N_TIMERS-1:0]          cfg_arm_i,
   input  logic [N_TIMERS-1:0]          cfg_oneshot_i,
   input  logic                         glb_start_i,
   input  logic                         glb_stop_i,
   input  logic [N_TIMERS-1:0]          glb_mask_i,
   input  logic [N_TIMERS-1:0]          status_clr_i,
   input  logic [N_TIMERS-1:0]          cnt_update_i,
   output logic [N_TIMERS-1:0]          ctrl_cnt_upd_o,
   output logic [N_TIMERS-1:0]          ctrl_all_upd_o,
   output logic [N_TIMERS-1:0]          ctrl_active_o,
   output logic [N_TIMERS-1:0]          ctrl_rst_o,
   output logic [N_TIMERS-1:0]          ctrl_arm_o,
   output logic [N_TIMERS*STATUS_W-1:0] status_o
);

   localparam bit DEFER_BIT = (DEFER_UPD != 0);

   logic [N_TIMERS-1:0] w_start_e;
   logic [N_TIMERS-1:0] w_stop_e;
   chan_stat_t          w_stat [N_TIMERS];

   // Arm requests need no sequencing and go straight to the slices
   assign ctrl_arm_o = cfg_arm_i;

   genvar gi;
   generate
      for (gi = 0; gi < N_TIMERS; gi = gi + 1) begin : g_chan
         logic [STATUS_W-1:0] w_word;

         // Local and global strobes merge, so a channel sees at most one start per cycle
         assign w_start_e[gi] = cfg_start_i[gi] | (glb_start_i & glb_mask_i[gi]);
         assign w_stop_e[gi]  = cfg_stop_i[gi]  | (glb_stop_i  & glb_mask_i[gi]);

         timer_cntrl_chan #(
            .DEFER_UPD (DEFER_BIT)
         ) u_chan (
            .clk_i          (clk_i),
            .rstn_i         (rstn_i),
            .start_e_i      (w_start_e[gi]),
            .stop_e_i       (w_stop_e[gi]),
            .cfg_rst_i      (cfg_rst_i[gi]),
            .cfg_update_i   (cfg_update_i[gi]),
            .cfg_oneshot_i  (cfg_oneshot_i[gi]),
            .status_clr_i   (status_clr_i[gi]),
            .cnt_update_i   (cnt_update_i[gi]),
            .ctrl_cnt_upd_o (ctrl_cnt_upd_o[gi]),
            .ctrl_all_upd_o (ctrl_all_upd_o[gi]),
            .ctrl_rst_o     (ctrl_rst_o[gi]),
            .ctrl_active_o  (ctrl_active_o[gi]),
            .stat_o         (w_stat[gi])
         );

         // Place the channel flags at their fixed bit positions; upper bits read zero
         always_comb begin
            w_word               = '0;
            w_word[STAT_PENDING] = w_stat[gi].pending;
            w_word[STAT_ACTIVE]  = w_stat[gi].active;
            w_word[STAT_DONE]    = w_stat[gi].done;
         end

         assign status_o[gi*STATUS_W +: STATUS_W] = w_word;
      end
   endgenerate

endmodule

// File: tb/tb_adv_timer_multi_cntrl.sv
// Self-checking bench for adv_timer_multi_cntrl: directed scenarios plus a random
// phase, with next-cycle registered results queued in a scoreboard.
module tb_adv_timer_multi_cntrl;
   localparam int N  = 4;
   localparam int SW = 8;

   logic            clk_i = 1'b0;
   logic            rstn_i = 1'b0;
   logic [N-1:0]    cfg_start_i, cfg_stop_i, cfg_rst_i, cfg_update_i, cfg_arm_i, cfg_oneshot_i;
   logic            glb_start_i, glb_stop_i;
   logic [N-1:0]    glb_mask_i, status_clr_i, cnt_update_i;
   logic [N-1:0]    ctrl_cnt_upd_o, ctrl_all_upd_o, ctrl_active_o, ctrl_rst_o, ctrl_arm_o;
   logic [N*SW-1:0] status_o;

   adv_timer_multi_cntrl #(.N_TIMERS(N), .DEFER_UPD(1), .STATUS_W(SW)) dut (
      .clk_i          (clk_i),
      .rstn_i         (rstn_i),
      .cfg_start_i    (cfg_start_i),
      .cfg_stop_i     (cfg_stop_i),
      .cfg_rst_i      (cfg_rst_i),
      .cfg_update_i   (cfg_update_i),
      .cfg_arm_i      (cfg_arm_i),
      .cfg_oneshot_i  (cfg_oneshot_i),
      .glb_start_i    (glb_start_i),
      .glb_stop_i     (glb_stop_i),
      .glb_mask_i     (glb_mask_i),
      .status_clr_i   (status_clr_i),
      .cnt_update_i   (cnt_update_i),
      .ctrl_cnt_upd_o (ctrl_cnt_upd_o),
      .ctrl_all_upd_o (ctrl_all_upd_o),
      .ctrl_active_o  (ctrl_active_o),
      .ctrl_rst_o     (ctrl_rst_o),
      .ctrl_arm_o     (ctrl_arm_o),
      .status_o       (status_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [N-1:0]    act;
      logic [N*SW-1:0] stat;
   } exp_t;

   exp_t         sb_q[$];
   int           checks = 0;
   int           errors = 0;
   int           txn    = 0;
   logic [N-1:0] m_act, m_pend, m_done;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [N*SW-1:0] stat_word(input logic [N-1:0] d, input logic [N-1:0] a,
                                                 input logic [N-1:0] p);
      logic [N*SW-1:0] w;
      w = '0;
      for (int i = 0; i < N; i++) begin
         w[i*SW + 0] = p[i];
         w[i*SW + 1] = a[i];
         w[i*SW + 2] = d[i];
      end
      return w;
   endfunction

   task automatic clr_in();
      cfg_start_i = '0; cfg_stop_i = '0; cfg_rst_i = '0; cfg_update_i = '0;
      cfg_arm_i = '0; cfg_oneshot_i = '0; glb_start_i = 1'b0; glb_stop_i = 1'b0;
      glb_mask_i = '0; status_clr_i = '0; cnt_update_i = '0;
   endtask

   // Called at posedge+1 with inputs applied; returns at the next posedge+1
   task automatic cyc(input string tag);
      logic [N-1:0] e_rst, e_cu, e_au, n_act, n_pend, n_done;
      logic         se, pe, lau, aut;
      exp_t         e, g;
      #3;
      for (int i = 0; i < N; i++) begin
         se  = cfg_start_i[i] | (glb_start_i & glb_mask_i[i]);
         pe  = cfg_stop_i[i] | (glb_stop_i & glb_mask_i[i]);
         lau = se && !m_act[i];
         aut = !se && !pe && m_act[i] && cfg_oneshot_i[i] && cnt_update_i[i];
         e_rst[i] = lau ? 1'b1 : cfg_rst_i[i];
         e_cu[i]  = lau ? 1'b1 : cfg_update_i[i];
         e_au[i]  = lau ? 1'b1 : (cnt_update_i[i] && m_pend[i]);
         if (se)       n_act[i] = 1'b1;
         else if (pe)  n_act[i] = 1'b0;
         else if (aut) n_act[i] = 1'b0;
         else          n_act[i] = m_act[i];
         if (cfg_update_i[i])             n_pend[i] = 1'b1;
         else if (lau || cnt_update_i[i]) n_pend[i] = 1'b0;
         else                             n_pend[i] = m_pend[i];
         if (aut)                        n_done[i] = 1'b1;
         else if (lau || status_clr_i[i]) n_done[i] = 1'b0;
         else                            n_done[i] = m_done[i];
      end
      chk({tag, "_rst"},     64'(ctrl_rst_o),     64'(e_rst));
      chk({tag, "_cnt_upd"}, 64'(ctrl_cnt_upd_o), 64'(e_cu));
      chk({tag, "_all_upd"}, 64'(ctrl_all_upd_o), 64'(e_au));
      chk({tag, "_arm"},     64'(ctrl_arm_o),     64'(cfg_arm_i));
      e.act  = n_act;
      e.stat = stat_word(n_done, n_act, n_pend);
      sb_q.push_back(e);
      @(posedge clk_i);
      #1;
      g = sb_q.pop_front();
      chk({tag, "_active"}, 64'(ctrl_active_o), 64'(g.act));
      chk({tag, "_status"}, 64'(status_o),      64'(g.stat));
      m_act = n_act; m_pend = n_pend; m_done = n_done;
      txn++;
      $display("txn %0d %s active=%b status=%h", txn, tag, ctrl_active_o, status_o);
   endtask

   initial begin
      logic [SW-1:0] s;
      clr_in();
      m_act = '0; m_pend = '0; m_done = '0;
      #3;
      chk("reset_active", 64'(ctrl_active_o), 64'd0);
      chk("reset_status", 64'(status_o), 64'd0);
      chk("reset_rst", 64'(ctrl_rst_o), 64'd0);
      repeat (2) @(posedge clk_i);
      #1 rstn_i = 1'b1;

      // 1: local start launches channel 0
      cfg_start_i = 4'b0001;
      #1 chk("t1_launch_rst", 64'(ctrl_rst_o), 64'h1);
      chk("t1_launch_all", 64'(ctrl_all_upd_o), 64'h1);
      cyc("t1_start"); clr_in();
      s = status_o[7:0];
      chk("t1_active0", 64'(ctrl_active_o[0]), 64'd1);
      chk("t1_status0", 64'(s), 64'h02);
      cfg_stop_i = 4'b0001; cyc("t1_stop"); clr_in();

      // 2: masked global start launches ch1 and ch3 together
      glb_mask_i = 4'b1010; glb_start_i = 1'b1;
      #1 chk("t2_launch_cnt", 64'(ctrl_cnt_upd_o), 64'hA);
      cyc("t2_glb_start"); clr_in();
      chk("t2_active", 64'(ctrl_active_o), 64'hA);

      // 3: deferred shadow update on ch2
      cfg_start_i = 4'b0100; cyc("t3_start"); clr_in();
      cfg_update_i = 4'b0100; cyc("t3_cfg_upd"); clr_in();
      s = status_o[23:16];
      chk("t3_pending", 64'(s), 64'h03);
      cnt_update_i = 4'b0100;
      #1 chk("t3_all_upd_on", 64'(ctrl_all_upd_o[2]), 64'd1);
      cyc("t3_cnt_upd1"); clr_in();
      cnt_update_i = 4'b0100;
      #1 chk("t3_all_upd_off", 64'(ctrl_all_upd_o[2]), 64'd0);
      cyc("t3_cnt_upd2"); clr_in();

      // 4: request and consume in the same cycle keeps pending set
      cfg_update_i = 4'b0001; cnt_update_i = 4'b0001; cyc("t4_both"); clr_in();
      s = status_o[7:0];
      chk("t4_pending0", 64'(s), 64'h01);

      // 5: one-shot auto-stop on ch1, then clear done
      cfg_oneshot_i = 4'b0010; cnt_update_i = 4'b0010; cyc("t5_oneshot"); clr_in();
      s = status_o[15:8];
      chk("t5_active1", 64'(ctrl_active_o[1]), 64'd0);
      chk("t5_done1", 64'(s), 64'h04);
      status_clr_i = 4'b0010; cyc("t5_clr"); clr_in();
      s = status_o[15:8];
      chk("t5_cleared1", 64'(s), 64'h00);

      // 6: asynchronous reset mid-run, then relaunch
      cfg_start_i = 4'b0001; cyc("t6_start"); clr_in();
      cyc("t6_run");
      rstn_i = 1'b0;
      #1;
      chk("t6_rst_active", 64'(ctrl_active_o), 64'd0);
      chk("t6_rst_status", 64'(status_o), 64'd0);
      m_act = '0; m_pend = '0; m_done = '0;
      @(posedge clk_i);
      #1 rstn_i = 1'b1;
      cfg_start_i = 4'b0001;
      #1 chk("t6_relaunch_rst", 64'(ctrl_rst_o[0]), 64'd1);
      cyc("t6_relaunch"); clr_in();

      // 7: start beats stop; start while active gives no launch pulse
      cfg_start_i = 4'b0010; cfg_stop_i = 4'b0010; cyc("t7_start_stop"); clr_in();
      chk("t7_active1", 64'(ctrl_active_o[1]), 64'd1);
      cfg_start_i = 4'b0010;
      #1 chk("t7_no_rst", 64'(ctrl_rst_o[1]), 64'd0);
      chk("t7_no_cnt_upd", 64'(ctrl_cnt_upd_o[1]), 64'd0);
      cyc("t7_restart"); clr_in();

      // Random phase against the scoreboard model
      for (int k = 0; k < 300; k++) begin
         cfg_start_i   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         cfg_stop_i    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         cfg_rst_i     = 4'($urandom_range(0, 15));
         cfg_update_i  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         cfg_arm_i     = 4'($urandom_range(0, 15));
         cfg_oneshot_i = 4'($urandom_range(0, 15));
         glb_start_i   = ($urandom_range(0, 7) == 0);
         glb_stop_i    = ($urandom_range(0, 7) == 0);
         glb_mask_i    = 4'($urandom_range(0, 15));
         status_clr_i  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         cnt_update_i  = 4'($urandom_range(0, 15));
         cyc("rnd");
      end
      clr_in();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
